// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - frame buffer geometry and render sequencer state type
package fb_pkg;
  localparam int FB_PIXELS = 76800;
  localparam int FB_ADDR_W = $clog2(FB_PIXELS);
  localparam int FB_DATA_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VSYNC,
    SELECT,
    START,
    WAIT_ACK,
    WAIT_DONE,
    ADVANCE,
    FINISH
  } seq_state_t;
endpackage

// File: rtl/fb_write_mux.sv
// rtl/fb_write_mux.sv - routes the active drawing engine's write port to the frame buffer
module fb_write_mux #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 24,
  parameter int IDX_W       = 2
) (
  input  logic                          valid,
  input  logic [IDX_W-1:0]              idx,
  input  logic [NUM_CLIENTS-1:0]        client_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] client_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] client_data,
  output logic                          we,
  output logic [ADDR_W-1:0]             addr,
  output logic [DATA_W-1:0]             data
);
  // Zero latency so the engine's we/addr/data stay aligned at the RAM.
  always_comb begin
    we   = 1'b0;
    addr = '0;
    data = '0;
    if (valid) begin
      we   = client_we[idx];
      addr = client_addr[idx*ADDR_W +: ADDR_W];
      data = client_data[idx*DATA_W +: DATA_W];
    end
  end
endmodule

// File: rtl/frame_render_sequencer.sv
// rtl/frame_render_sequencer.sv - per-frame start/done sequencing of drawing engines
// with write-port arbitration and double-buffer flip
module frame_render_sequencer
  import fb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int DATA_W      = FB_DATA_W,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          vsync,
  input  logic [NUM_CLIENTS-1:0]        client_en,
  output logic [NUM_CLIENTS-1:0]        client_start,
  input  logic [NUM_CLIENTS-1:0]        client_done,
  input  logic [NUM_CLIENTS-1:0]        client_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] client_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] client_data,
  output logic                          fb_we,
  output logic [ADDR_W-1:0]             fb_addr,
  output logic [DATA_W-1:0]             fb_data,
  output logic                          fb_draw_sel,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overrun,
  output logic                          ack_err
);
  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLIENTS - 1);

  seq_state_t              state;
  logic [IDX_W-1:0]        idx;
  logic [NUM_CLIENTS-1:0]  en_q;
  logic [CNT_W-1:0]        ack_cnt;
  logic                    frame_ready;
  logic                    vsync_q;
  logic                    vsync_rise;
  logic                    mux_valid;

  assign vsync_rise = vsync & ~vsync_q;
  assign mux_valid  = state inside {START, WAIT_ACK, WAIT_DONE};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      en_q         <= '0;
      ack_cnt      <= '0;
      frame_ready  <= 1'b0;
      vsync_q      <= 1'b0;
      client_start <= '0;
      fb_draw_sel  <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
      ack_err      <= 1'b0;
    end else begin
      vsync_q      <= vsync;
      client_start <= '0;
      frame_done   <= 1'b0;
      // A late vsync never restarts or swaps; it is only recorded.
      if (vsync_rise && !(state inside {IDLE, WAIT_VSYNC}))
        overrun <= 1'b1;
      case (state)
        IDLE: if (enable) state <= WAIT_VSYNC;
        WAIT_VSYNC: begin
          if (vsync_rise) begin
            if (frame_ready) begin
              fb_draw_sel <= ~fb_draw_sel;
              frame_ready <= 1'b0;
            end
            en_q  <= client_en;
            idx   <= '0;
            busy  <= 1'b1;
            state <= SELECT;
          end else if (!enable) begin
            state <= IDLE;
          end
        end
        SELECT: begin
          if (en_q[idx]) begin
            client_start <= NUM_CLIENTS'(1) << idx;
            state        <= START;
          end else if (idx == LAST) begin
            frame_done  <= 1'b1;
            frame_ready <= 1'b1;
            state       <= FINISH;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        START: begin
          ack_cnt <= '0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!client_done[idx]) begin
            state <= WAIT_DONE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
            if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
              ack_err <= 1'b1;
              state   <= ADVANCE;
            end
          end
        end
        WAIT_DONE: if (client_done[idx]) state <= ADVANCE;
        ADVANCE: begin
          if (idx == LAST) begin
            frame_done  <= 1'b1;
            frame_ready <= 1'b1;
            state       <= FINISH;
          end else begin
            idx   <= idx + 1'b1;
            state <= SELECT;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= enable ? WAIT_VSYNC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fb_write_mux #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .IDX_W      (IDX_W)
  ) u_write_mux (
    .valid      (mux_valid),
    .idx        (idx),
    .client_we  (client_we),
    .client_addr(client_addr),
    .client_data(client_data),
    .we         (fb_we),
    .addr       (fb_addr),
    .data       (fb_data)
  );
endmodule

// File: tb/tb_frame_render_sequencer.sv
// tb/tb_frame_render_sequencer.sv - self-checking bench for frame_render_sequencer
module tb_frame_render_sequencer;
  localparam int N  = 2;
  localparam int AW = 17;
  localparam int DW = 24;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          vsync = 1'b0;
  logic [N-1:0]  client_en = '0;
  logic [N-1:0]  client_start;
  logic [N-1:0]  client_done = '1;
  logic [N-1:0]  client_we = '0;
  logic [N*AW-1:0] client_addr = '0;
  logic [N*DW-1:0] client_data = '0;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_data;
  logic          fb_draw_sel, busy, frame_done, overrun, ack_err;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  frame_render_sequencer #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .vsync(vsync), .client_en(client_en),
    .client_start(client_start), .client_done(client_done), .client_we(client_we),
    .client_addr(client_addr), .client_data(client_data), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .fb_draw_sel(fb_draw_sel), .busy(busy), .frame_done(frame_done),
    .overrun(overrun), .ack_err(ack_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural engines: done drops one cycle after start, four writes at 0..3, then idle.
  int           cnt [N];
  logic [N-1:0] stuck = '0;
  logic         rogue0 = 1'b0;
  logic [N-1:0] st_seen;
  initial for (int i = 0; i < N; i++) cnt[i] = -1;
  always @(posedge clk) begin
    st_seen = client_start;
    #1;
    for (int i = 0; i < N; i++) begin
      if (rst) cnt[i] = -1;
      else if (st_seen[i] && !stuck[i]) cnt[i] = 0;
      else if (cnt[i] >= 3) cnt[i] = -1;
      else if (cnt[i] >= 0) cnt[i]++;
      client_done[i] = (cnt[i] < 0);
      client_we[i]   = (cnt[i] >= 0);
      client_addr[i*AW +: AW] = (cnt[i] >= 0) ? AW'(cnt[i]) : '0;
      client_data[i*DW +: DW] = (cnt[i] >= 0) ? {8'(i + 1), 16'(cnt[i])} : '0;
    end
    if (rogue0 && cnt[0] < 0) begin
      client_we[0] = 1'b1;
      client_addr[0 +: AW] = AW'(5);
      client_data[0 +: DW] = 24'hbad000;
    end
  end

  // Reference model: a procedural walk of one frame, cycle by cycle.
  logic [N-1:0] exp_start;
  logic exp_fd, exp_busy, exp_sel, exp_ovr, exp_ackerr;
  int   mact;
  logic m_vq, m_rise, m_ready, mrst;

  task automatic tick();
    @(posedge clk);
    exp_start = '0;
    exp_fd    = 1'b0;
    mrst      = 1'b0;
    if (rst) begin
      exp_busy = 0; exp_sel = 0; exp_ovr = 0; exp_ackerr = 0;
      mact = -1; m_vq = 0; m_ready = 0; m_rise = 0; mrst = 1;
    end else begin
      m_rise = vsync & ~m_vq;
      m_vq   = vsync;
      if (exp_busy && m_rise) exp_ovr = 1'b1;
    end
  endtask

  task automatic run_frame(input logic [N-1:0] en);
    bit acked;
    int k;
    exp_busy = 1'b1;
    for (int i = 0; i < N; i++) begin
      tick(); if (mrst) return;
      if (en[i]) begin
        exp_start = N'(1) << i;
        mact = i;
        tick(); if (mrst) return;
        acked = 0;
        k = 0;
        while (!acked && k < TO) begin
          tick(); if (mrst) return;
          if (!client_done[i]) acked = 1;
          else k++;
        end
        if (!acked) exp_ackerr = 1'b1;
        else begin
          do begin
            tick(); if (mrst) return;
          end while (!client_done[i]);
        end
        mact = -1;
        tick(); if (mrst) return;
      end
    end
    exp_fd  = 1'b1;
    m_ready = 1'b1;
    tick(); if (mrst) return;
    exp_busy = 1'b0;
  endtask

  initial begin : model
    bit armed, go;
    exp_start = '0; exp_fd = 0; exp_busy = 0; exp_sel = 0; exp_ovr = 0; exp_ackerr = 0;
    mact = -1; m_vq = 0; m_ready = 0; mrst = 0; m_rise = 0; armed = 0;
    forever begin
      go = 0;
      while (!go) begin
        tick();
        if (mrst) armed = 0;
        else if (!armed) armed = enable;
        else if (m_rise) go = 1;
        else if (!enable) armed = 0;
      end
      if (m_ready) begin
        exp_sel = ~exp_sel;
        m_ready = 0;
      end
      run_frame(client_en);
      armed = mrst ? 1'b0 : enable;
    end
  end

  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  always @(negedge clk) begin
    e_we = 1'b0; e_addr = '0; e_data = '0;
    if (!rst && mact >= 0) begin
      e_we   = client_we[mact];
      e_addr = client_addr[mact*AW +: AW];
      e_data = client_data[mact*DW +: DW];
    end
    chk("client_start", 32'(client_start), rst ? 32'd0 : 32'(exp_start));
    chk("frame_done",   32'(frame_done),   rst ? 32'd0 : 32'(exp_fd));
    chk("busy",         32'(busy),         rst ? 32'd0 : 32'(exp_busy));
    chk("fb_draw_sel",  32'(fb_draw_sel),  rst ? 32'd0 : 32'(exp_sel));
    chk("overrun",      32'(overrun),      rst ? 32'd0 : 32'(exp_ovr));
    chk("ack_err",      32'(ack_err),      rst ? 32'd0 : 32'(exp_ackerr));
    chk("fb_we",        32'(fb_we),        32'(e_we));
    chk("fb_addr",      32'(fb_addr),      32'(e_addr));
    chk("fb_data",      32'(fb_data),      32'(e_data));
  end

  int tot_fd = 0, tot_we = 0, tot_st0 = 0, tot_rogue = 0;
  always @(negedge clk) begin
    if (frame_done) tot_fd++;
    if (fb_we) tot_we++;
    if (client_start[0]) tot_st0++;
    if (fb_we && fb_addr == AW'(5)) tot_rogue++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    cyc(1);
    vsync = 1'b0;
  endtask

  task automatic wait_fd(input string name, input int lim);
    int k;
    k = 0;
    while (!frame_done && k < lim) begin
      cyc(1);
      k++;
    end
    chk(name, 32'(frame_done), 32'd1);
    cyc(1);
  endtask

  task automatic wait_cnt0(input string name);
    int k;
    k = 0;
    while (cnt[0] != 1 && k < 40) begin
      cyc(1);
      k++;
    end
    chk(name, 32'(cnt[0]), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int lat, fd0, we0, st0, rg0;
    logic sel0;
    cyc(3);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_sel", 32'(fb_draw_sel), 32'd0);
    rst = 1'b0;
    enable = 1'b1;
    client_en = 2'b11;
    cyc(3);

    // Frame 1: both engines, start latency, write count, no swap yet.
    fd0 = tot_fd; we0 = tot_we;
    vsync = 1'b1;
    cyc(1);
    vsync = 1'b0;
    lat = 1;
    while (client_start !== 2'b01 && lat < 10) begin
      cyc(1);
      lat++;
    end
    chk("start0_latency", lat, 32'd2);
    wait_fd("f1_frame_done", 60);
    chk("f1_writes", tot_we - we0, 32'd8);
    chk("f1_done_pulses", tot_fd - fd0, 32'd1);
    chk("f1_sel", 32'(fb_draw_sel), 32'd0);

    // Frame 2: swap on the edge cycle.
    pulse_vsync();
    chk("f2_swap", 32'(fb_draw_sel), 32'd1);
    wait_fd("f2_frame_done", 60);

    // Frame 3: client 0 masked and writing anyway.
    client_en = 2'b10; rogue0 = 1'b1;
    st0 = tot_st0; rg0 = tot_rogue; we0 = tot_we;
    pulse_vsync();
    wait_fd("f3_frame_done", 60);
    rogue0 = 1'b0;
    chk("f3_no_start0", tot_st0 - st0, 32'd0);
    chk("f3_no_rogue", tot_rogue - rg0, 32'd0);
    chk("f3_writes", tot_we - we0, 32'd4);

    // No engines enabled: frame_done three cycles after the edge.
    client_en = 2'b00;
    vsync = 1'b1;
    cyc(1);
    vsync = 1'b0;
    lat = 1;
    while (!frame_done && lat < 10) begin
      cyc(1);
      lat++;
    end
    chk("empty_frame_latency", lat, 32'd3);
    cyc(2);

    // Frame 4: client 1 never acknowledges.
    client_en = 2'b10; stuck = 2'b10;
    pulse_vsync();
    wait_fd("f4_frame_done", 60);
    stuck = '0;
    chk("f4_ack_err", 32'(ack_err), 32'd1);
    chk("f4_overrun", 32'(overrun), 32'd0);

    // Frame 5: vsync while client 0 is drawing.
    client_en = 2'b01;
    st0 = tot_st0; fd0 = tot_fd;
    pulse_vsync();
    wait_cnt0("f5_reach_draw");
    sel0 = fb_draw_sel;
    pulse_vsync();
    wait_fd("f5_frame_done", 60);
    chk("f5_overrun", 32'(overrun), 32'd1);
    chk("f5_no_swap", 32'(fb_draw_sel), 32'(sel0));
    cyc(10);
    chk("f5_no_restart", tot_st0 - st0, 32'd1);
    chk("f5_done_pulses", tot_fd - fd0, 32'd1);

    // Reset in the middle of client 0's drawing.
    pulse_vsync();
    wait_cnt0("f6_reach_draw");
    rst = 1'b1;
    cyc(1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sel", 32'(fb_draw_sel), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_ack_err", 32'(ack_err), 32'd0);
    chk("rst_start", 32'(client_start), 32'd0);
    chk("rst_fb_we", 32'(fb_we), 32'd0);
    rst = 1'b0;
    client_en = 2'b00;
    cyc(3);
    pulse_vsync();
    wait_fd("post_rst_frame_done", 20);
    chk("post_rst_sel", 32'(fb_draw_sel), 32'd0);
    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
